// File: rtl/formatador_pkg.sv
// Shared constants for the serial report formatter: ASCII codes and FSM states.
package formatador_pkg;

  localparam logic [6:0] HEXA_30 = 7'h30;
  localparam logic [6:0] HEXA_37 = 7'h37;
  localparam logic [6:0] HEXA_23 = 7'h23;
  localparam logic [6:0] HEXA_2C = 7'h2C;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    PREPARA   = 3'd1,
    TRANSMITE = 3'd2,
    ESPERA    = 3'd3,
    PROXIMO   = 3'd4,
    FIM       = 3'd5
  } estado_t;

endpackage

// File: rtl/hex_para_ascii.sv
// Nibble to ASCII hex digit; 0-9 map to '0'-'9', A-F map to 'A'-'F'.
module hex_para_ascii
  import formatador_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = HEXA_30 + {3'b000, nibble};
    else                ascii = HEXA_37 + {3'b000, nibble};
  end

endmodule

// File: rtl/formatador_serial_n.sv
// Snapshots N_CANAIS measurements on start and streams them as hex text,
// one character per partida/pronto handshake with the serial transmitter.
module formatador_serial_n
  import formatador_pkg::*;
#(
  parameter int         N_CANAIS = 3,
  parameter int         W        = 12,
  parameter int         DIGITOS  = W / 4,
  parameter logic [6:0] SEP      = HEXA_2C,
  parameter logic [6:0] TERM     = HEXA_23
) (
  input  logic                  clock,
  input  logic                  zera,
  input  logic                  iniciar,
  input  logic [N_CANAIS*W-1:0] medidas,
  input  logic                  tx_pronto,
  output logic                  tx_partida,
  output logic [6:0]            tx_dado,
  output logic                  ocupado,
  output logic                  fim_mensagem,
  output logic [2:0]            db_estado
);

  localparam int CW = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1;
  localparam int DW = $clog2(DIGITOS + 1);
  localparam logic [CW-1:0] ULT_C   = CW'(N_CANAIS - 1);
  localparam logic [DW-1:0] POS_SEP = DW'(DIGITOS);

  estado_t               estado, prox;
  logic [N_CANAIS*W-1:0] snapshot;
  logic [CW-1:0]         idx_c;
  logic [DW-1:0]         idx_d;
  logic [W-1:0]          canal;
  logic [3:0]            nibble;
  logic [6:0]            hex_char, caractere;
  logic                  ultimo;

  // Channel and nibble are picked with compare loops so no unused slice bits remain.
  always_comb begin
    canal = '0;
    for (int c = 0; c < N_CANAIS; c++)
      if (CW'(c) == idx_c) canal = snapshot[c*W +: W];
    nibble = 4'h0;
    for (int d = 0; d < DIGITOS; d++)
      if (DW'(d) == idx_d) nibble = canal[W-1-4*d -: 4];
  end

  hex_para_ascii u_hex (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  always_comb begin
    ultimo    = (idx_c == ULT_C) && (idx_d == POS_SEP);
    caractere = hex_char;
    if (idx_d == POS_SEP) caractere = (idx_c == ULT_C) ? TERM : SEP;
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:    if (iniciar) prox = PREPARA;
      PREPARA:   prox = TRANSMITE;
      TRANSMITE: prox = ESPERA;
      ESPERA:    if (tx_pronto) prox = PROXIMO;
      PROXIMO:   prox = ultimo ? FIM : PREPARA;
      FIM:       prox = OCIOSO;
      default:   prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (zera) estado <= OCIOSO;
    else      estado <= prox;
  end

  always_ff @(posedge clock) begin
    if (zera) begin
      snapshot <= '0;
      idx_c    <= '0;
      idx_d    <= '0;
      tx_dado  <= 7'h00;
    end else begin
      case (estado)
        OCIOSO: if (iniciar) begin
          snapshot <= medidas;
          idx_c    <= '0;
          idx_d    <= '0;
        end
        PREPARA: tx_dado <= caractere;
        PROXIMO: if (!ultimo) begin
          if (idx_d == POS_SEP) begin
            idx_d <= '0;
            idx_c <= idx_c + CW'(1);
          end else begin
            idx_d <= idx_d + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_partida   = (estado == TRANSMITE);
  assign ocupado      = (estado != OCIOSO);
  assign fim_mensagem = (estado == FIM);
  assign db_estado    = estado;

endmodule

// File: tb/tb_formatador_serial_n.sv
// Directed bench: text model of the report, per-cycle compare against two instances.
module tb_formatador_serial_n;

  logic        clock = 1'b0;
  logic        zera, iniciar_a, iniciar_b, stray;
  logic [35:0] medidas_a;
  logic [7:0]  medidas_b;
  logic        resp_a, resp_b, tx_pronto_a, tx_pronto_b;
  logic        tx_partida_a, ocupado_a, fim_a, tx_partida_b, ocupado_b, fim_b;
  logic [6:0]  tx_dado_a, tx_dado_b, held_a, held_b;
  logic [2:0]  db_estado_a, db_estado_b;

  int    total = 0, bad = 0;
  int    pos_a, pos_b, parts_a, parts_b, fims_a, fims_b, cnt_a, cnt_b;
  string exp_a, rx_a, exp_b, rx_b;
  string L1 = "1A3,0FF,ABC#";

  always #5 clock = ~clock;
  assign tx_pronto_a = resp_a | stray;
  assign tx_pronto_b = resp_b;

  formatador_serial_n dut_a (
    .clock(clock), .zera(zera), .iniciar(iniciar_a), .medidas(medidas_a),
    .tx_pronto(tx_pronto_a), .tx_partida(tx_partida_a), .tx_dado(tx_dado_a),
    .ocupado(ocupado_a), .fim_mensagem(fim_a), .db_estado(db_estado_a));

  formatador_serial_n #(.N_CANAIS(1), .W(8)) dut_b (
    .clock(clock), .zera(zera), .iniciar(iniciar_b), .medidas(medidas_b),
    .tx_pronto(tx_pronto_b), .tx_partida(tx_partida_b), .tx_dado(tx_dado_b),
    .ocupado(ocupado_b), .fim_mensagem(fim_b), .db_estado(db_estado_b));

  // Expected report text straight from the message rules.
  function automatic string modelo(logic [63:0] m, int n, int w);
    string s = "";
    int    nib;
    for (int c = 0; c < n; c++) begin
      for (int d = 0; d < w / 4; d++) begin
        nib = int'((m >> (c*w + w - 4 - 4*d)) & 64'hF);
        s = $sformatf("%s%c", s, (nib < 10) ? (48 + nib) : (65 + nib - 10));
      end
      s = $sformatf("%s%c", s, (c == n - 1) ? 35 : 44);
    end
    return s;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic chks(string nm, string act, string expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, expv);
    end
  endtask

  task automatic monitor();
    if (tx_partida_a) begin
      chk("a_ocupado_at_partida", 64'(ocupado_a), 64'd1);
      if (pos_a < exp_a.len()) chk("a_char", 64'(tx_dado_a), 64'(exp_a[pos_a]));
      else begin total++; bad++; $display("FAIL a_extra_partida: got %0d expected %0d", pos_a + 1, exp_a.len()); end
      rx_a = $sformatf("%s%c", rx_a, tx_dado_a);
      held_a = tx_dado_a; pos_a++; parts_a++;
    end else if (db_estado_a == 3'd2 || db_estado_a == 3'd3)
      chk("a_dado_stable", 64'(tx_dado_a), 64'(held_a));
    chk("a_ocupado", 64'(ocupado_a), 64'(db_estado_a != 3'd0));
    if (fim_a) begin fims_a++; chk("a_fim_all_sent", 64'(pos_a), 64'(exp_a.len())); end
    if (tx_partida_b) begin
      if (pos_b < exp_b.len()) chk("b_char", 64'(tx_dado_b), 64'(exp_b[pos_b]));
      else begin total++; bad++; $display("FAIL b_extra_partida: got %0d expected %0d", pos_b + 1, exp_b.len()); end
      rx_b = $sformatf("%s%c", rx_b, tx_dado_b);
      held_b = tx_dado_b; pos_b++; parts_b++;
    end else if (db_estado_b == 3'd2 || db_estado_b == 3'd3)
      chk("b_dado_stable", 64'(tx_dado_b), 64'(held_b));
    if (fim_b) begin fims_b++; chk("b_fim_all_sent", 64'(pos_b), 64'(exp_b.len())); end
  endtask

  // TX stand-in: pronto 10 cycles after each partida.
  task automatic responder();
    if (zera) begin cnt_a = 0; resp_a = 0; cnt_b = 0; resp_b = 0; end
    else begin
      if (tx_partida_a) begin cnt_a = 10; resp_a = 0; end
      else if (cnt_a == 1) begin cnt_a = 0; resp_a = 1; end
      else begin if (cnt_a > 0) cnt_a--; resp_a = 0; end
      if (tx_partida_b) begin cnt_b = 10; resp_b = 0; end
      else if (cnt_b == 1) begin cnt_b = 0; resp_b = 1; end
      else begin if (cnt_b > 0) cnt_b--; resp_b = 0; end
    end
  endtask

  task automatic start_a(logic [35:0] m);
    exp_a = modelo(64'(m), 3, 12); rx_a = ""; pos_a = 0; parts_a = 0; fims_a = 0;
    medidas_a = m; iniciar_a = 1;
    @(negedge clock); iniciar_a = 0;
  endtask

  task automatic wait_fim_a();
    int n = 0;
    while (!fim_a && n < 1000) begin @(negedge clock); n++; end
    if (!fim_a) begin total++; bad++; $display("FAIL a_timeout: got no fim expected fim"); end
  endtask

  task automatic wait_a(int parts, logic [2:0] st);
    int n = 0;
    while (!(parts_a == parts && db_estado_a == st) && n < 1000) begin @(negedge clock); n++; end
    if (n >= 1000) begin total++; bad++; $display("FAIL a_wait_timeout: got parts %0d expected %0d", parts_a, parts); end
  endtask

  task automatic end_msg_a(string nm);
    @(negedge clock);
    chks({nm, "_text"}, rx_a, L1);
    chk({nm, "_partidas"}, 64'(parts_a), 64'd12);
    chk({nm, "_fims"}, 64'(fims_a), 64'd1);
  endtask

  initial begin
    zera = 1; iniciar_a = 0; iniciar_b = 0; stray = 0; medidas_a = '0; medidas_b = '0;
    resp_a = 0; resp_b = 0; cnt_a = 0; cnt_b = 0; held_a = '0; held_b = '0;
    pos_a = 0; pos_b = 0; parts_a = 0; parts_b = 0; fims_a = 0; fims_b = 0;
    exp_a = ""; exp_b = ""; rx_a = ""; rx_b = "";
    repeat (3) @(negedge clock);
    chk("rst_partida", 64'(tx_partida_a), 64'd0);
    chk("rst_dado", 64'(tx_dado_a), 64'd0);
    chk("rst_ocupado", 64'(ocupado_a), 64'd0);
    chk("rst_fim", 64'(fim_a), 64'd0);
    chk("rst_estado", 64'(db_estado_a), 64'd0);
    chk("rst_b_dado", 64'(tx_dado_b), 64'd0);
    zera = 0;
    chks("model_pin_a", modelo(64'h0ABC0FF1A3, 3, 12), L1);
    chks("model_pin_ones", modelo(64'hFFFFFFFFF, 3, 12), "FFF,FFF,FFF#");
    chks("model_pin_b", modelo(64'h7F, 1, 8), "7F#");
    fork
      forever @(negedge clock) begin monitor(); responder(); end
    join_none
    @(negedge clock);

    // 1: basic message, start latency, iniciar in FIM ignored
    start_a(36'hABC0FF1A3);
    chk("lat_prepara_partida", 64'(tx_partida_a), 64'd0);
    chk("lat_prepara_estado", 64'(db_estado_a), 64'd1);
    @(negedge clock);
    chk("lat_partida", 64'(tx_partida_a), 64'd1);
    wait_fim_a();
    iniciar_a = 1;
    @(negedge clock); iniciar_a = 0;
    chks("t1_text", rx_a, L1);
    chk("t1_partidas", 64'(parts_a), 64'd12);
    chk("t1_fims", 64'(fims_a), 64'd1);
    @(negedge clock);
    chk("t1_fim_iniciar_ignored", 64'(ocupado_a), 64'd0);
    repeat (3) @(negedge clock);

    // 2: iniciar during char 5 is ignored
    start_a(36'hABC0FF1A3);
    wait_a(5, 3'd3);
    iniciar_a = 1; @(negedge clock); iniciar_a = 0;
    wait_fim_a(); end_msg_a("t2");
    repeat (30) @(negedge clock);
    chk("t2_no_second_msg", 64'(parts_a), 64'd12);
    chk("t2_idle", 64'(ocupado_a), 64'd0);

    // 3: reset in ESPERA of char 7, then a fresh message
    start_a(36'hABC0FF1A3);
    wait_a(7, 3'd3);
    zera = 1;
    @(negedge clock);
    chk("t3_partida", 64'(tx_partida_a), 64'd0);
    chk("t3_dado", 64'(tx_dado_a), 64'd0);
    chk("t3_ocupado", 64'(ocupado_a), 64'd0);
    chk("t3_fim", 64'(fim_a), 64'd0);
    chk("t3_estado", 64'(db_estado_a), 64'd0);
    @(negedge clock); zera = 0;
    chk("t3_no_fim_after_abort", 64'(fims_a), 64'd0);
    @(negedge clock);
    start_a(36'hABC0FF1A3);
    wait_fim_a(); end_msg_a("t3");

    // 4: medidas change after start; snapshot is sent
    repeat (2) @(negedge clock);
    start_a(36'hABC0FF1A3);
    medidas_a = '1;
    wait_fim_a(); end_msg_a("t4");

    // 5: stray pronto in OCIOSO and in TRANSMITE
    repeat (2) @(negedge clock);
    stray = 1; @(negedge clock); stray = 0;
    chk("t5_idle_estado", 64'(db_estado_a), 64'd0);
    @(negedge clock);
    start_a(36'hABC0FF1A3);
    begin
      int n = 0;
      while (!tx_partida_a && n < 50) begin @(negedge clock); n++; end
    end
    stray = 1; @(negedge clock); stray = 0;
    chk("t5_stray_no_advance", 64'(db_estado_a), 64'd3);
    wait_fim_a(); end_msg_a("t5");

    // 6: single 8-bit channel
    exp_b = modelo(64'h7F, 1, 8); rx_b = ""; pos_b = 0; parts_b = 0; fims_b = 0;
    medidas_b = 8'h7F; iniciar_b = 1;
    @(negedge clock); iniciar_b = 0;
    begin
      int n = 0;
      while (!fim_b && n < 500) begin @(negedge clock); n++; end
      if (!fim_b) begin total++; bad++; $display("FAIL b_timeout: got no fim expected fim"); end
    end
    @(negedge clock);
    chks("t6_text", rx_b, "7F#");
    chk("t6_partidas", 64'(parts_b), 64'd3);
    chk("t6_fims", 64'(fims_b), 64'd1);
    chk("t6_idle", 64'(ocupado_b), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
